// File: rtl/io_handshake_unit_pkg.sv
// Shared types for the I/O handshake unit: FSM state encoding, I/O mode
// encoding and the debounce counter width helper.
package armaria_io_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_ARMED        = 2'd1;
    localparam logic [1:0] ST_GRANT        = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        ARMED        = ST_ARMED,
        GRANT        = ST_GRANT,
        WAIT_RELEASE = ST_WAIT_RELEASE
    } io_state_e;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_INPUT  = 2'd1,
        MODE_OUTPUT = 2'd2,
        MODE_PAUSE  = 2'd3
    } io_mode_e;

    function automatic io_mode_e decode_mode(input logic is_input, input logic is_output);
        io_mode_e mode;
        case ({is_input, is_output})
            2'b10:   mode = MODE_INPUT;
            2'b01:   mode = MODE_OUTPUT;
            2'b11:   mode = MODE_PAUSE;
            default: mode = MODE_NONE;
        endcase
        return mode;
    endfunction

    function automatic int unsigned dbnc_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 32'd1);
    endfunction

endpackage

// File: rtl/io_handshake_unit_if.sv
// Handshake bundle between the control core / board keys (master) and the
// I/O handshake unit (slave).
interface io_handshake_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              is_input;
    logic              is_output;
    logic              confirm_key_raw;
    logic              continue_key_raw;
    logic [DATA_W-1:0] output_data;
    logic              confirmation;
    logic              continue_button;
    logic [DATA_W-1:0] display_value;
    logic              waiting;

    modport master (
        output is_input, is_output, confirm_key_raw, continue_key_raw, output_data,
        input  confirmation, continue_button, display_value, waiting
    );

    modport slave (
        input  is_input, is_output, confirm_key_raw, continue_key_raw, output_data,
        output confirmation, continue_button, display_value, waiting
    );
endinterface

// File: rtl/io_handshake_unit_key_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw board key.
// rise_o flags the cycle whose clock edge will raise the clean level.
module key_debouncer
    import armaria_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw_i,
    output logic level_o,
    output logic rise_o,
    output logic idle_o
);
    localparam int unsigned           CNT_W    = dbnc_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive synchronised samples that differ from the clean level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser resets to "pressed" so a key held through reset is never
    // mistaken for a fresh release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_d & ~level_q;
    assign idle_o  = ~level_q & ~sync_q[1];

endmodule

// File: rtl/io_handshake_unit.sv
// I/O handshake unit: one key press-release commits exactly one INPUT, OUTPUT
// or PAUSE instruction. Define IO_AUTOCONFIRM_EN to auto-grant without keys.
module io_handshake_unit
    import armaria_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DATA_W          = 32
) (
    input  logic               clock,
    input  logic               reset,
    io_handshake_unit_if.slave io
);
    io_state_e         state_q;
    io_mode_e          mode_q;
    logic              confirmation_q;
    logic              continue_q;
    logic              waiting_q;
    logic [DATA_W-1:0] display_q;

    logic     req_s;
    io_mode_e live_mode_s;
    logic     key_pause_s;
    logic     sel_idle_s;
    logic     grant_ok_s;
    logic     release_ok_s;
    logic     conf_level_s, conf_rise_s, conf_idle_s;
    logic     cont_level_s, cont_rise_s, cont_idle_s;
    logic     sel_level_s, sel_rise_s;

    assign req_s       = io.is_input | io.is_output;
    assign live_mode_s = decode_mode(io.is_input, io.is_output);

`ifdef IO_AUTOCONFIRM_EN
    assign conf_level_s = 1'b0;
    assign conf_rise_s  = 1'b0;
    assign conf_idle_s  = 1'b1;
    assign cont_level_s = 1'b0;
    assign cont_rise_s  = 1'b0;
    assign cont_idle_s  = 1'b1;
    assign grant_ok_s   = 1'b1;
    assign release_ok_s = 1'b1;
`else
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_conf_dbnc (
        .clock     (clock),
        .reset     (reset),
        .key_raw_i (io.confirm_key_raw),
        .level_o   (conf_level_s),
        .rise_o    (conf_rise_s),
        .idle_o    (conf_idle_s)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_dbnc (
        .clock     (clock),
        .reset     (reset),
        .key_raw_i (io.continue_key_raw),
        .level_o   (cont_level_s),
        .rise_o    (cont_rise_s),
        .idle_o    (cont_idle_s)
    );

    assign grant_ok_s   = sel_rise_s;
    assign release_ok_s = ~sel_level_s;
`endif

    // Key selection follows the live mode while idle, the latched mode once armed.
    always_comb begin
        key_pause_s = (state_q == IDLE) ? (live_mode_s == MODE_PAUSE) : (mode_q == MODE_PAUSE);
        if (key_pause_s) begin
            sel_level_s = cont_level_s;
            sel_rise_s  = cont_rise_s;
            sel_idle_s  = cont_idle_s;
        end else begin
            sel_level_s = conf_level_s;
            sel_rise_s  = conf_rise_s;
            sel_idle_s  = conf_idle_s;
        end
    end

    // Handshake FSM with registered strobes, waiting flag and display register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            mode_q         <= MODE_NONE;
            confirmation_q <= 1'b0;
            continue_q     <= 1'b0;
            waiting_q      <= 1'b0;
            display_q      <= '0;
        end else begin
            confirmation_q <= 1'b0;
            continue_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_s && sel_idle_s) begin
                        state_q   <= ARMED;
                        mode_q    <= live_mode_s;
                        waiting_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!req_s) begin
                        state_q   <= IDLE;
                        waiting_q <= 1'b0;
                    end else if (grant_ok_s) begin
                        state_q        <= GRANT;
                        waiting_q      <= 1'b0;
                        confirmation_q <= (mode_q != MODE_PAUSE);
                        continue_q     <= (mode_q == MODE_PAUSE);
                        if (io.is_output && !io.is_input) begin
                            display_q <= io.output_data;
                        end
                    end
                end
                GRANT: begin
                    state_q <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (release_ok_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    waiting_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.confirmation    = confirmation_q;
    assign io.continue_button = continue_q;
    assign io.waiting         = waiting_q;
    assign io.display_value   = display_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Scoreboard bench for io_handshake_unit with DEBOUNCE_CYCLES=4: stimulus
// queues expected strobes, a negedge monitor pops and compares them.
module tb_io_handshake_unit;
    localparam int unsigned DBNC = 4;
    localparam int unsigned DW   = 32;

    typedef struct packed {
        logic [1:0]  kind;   // {confirmation, continue_button}
        logic [31:0] cyc;
        logic [31:0] disp;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   passed = 0;
    int   total  = 0;
    exp_t exp_q[$];
    exp_t mon_got;
    exp_t mon_exp;

    always #5 clock = ~clock;

    io_handshake_unit_if #(.DATA_W(DW)) io_if ();

    io_handshake_unit #(.DEBOUNCE_CYCLES(DBNC), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io_if)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: every strobe cycle must match the oldest expected strobe.
    always @(negedge clock) begin
        if (reset && (io_if.confirmation || io_if.continue_button)) begin
            mon_got.kind = {io_if.confirmation, io_if.continue_button};
            mon_got.cyc  = 32'(cyc);
            mon_got.disp = io_if.display_value;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", mon_got, 96'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe", mon_got, mon_exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Press a key now and expect the strobe after sync (2) + debounce (4) edges.
    task automatic press(input bit use_cont, input logic [1:0] kind, input int lat,
                         input logic [31:0] disp);
        exp_t e;
        e.kind = kind;
        e.cyc  = 32'(cyc + lat);
        e.disp = disp;
        exp_q.push_back(e);
        if (use_cont) io_if.continue_key_raw = 1'b1;
        else          io_if.confirm_key_raw  = 1'b1;
    endtask

    task automatic drain(input string name);
        tick(10);
        io_if.confirm_key_raw  = 1'b0;
        io_if.continue_key_raw = 1'b0;
        io_if.is_input         = 1'b0;
        io_if.is_output        = 1'b0;
        tick(10);
        check(name, 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        io_if.is_input         = 1'b0;
        io_if.is_output        = 1'b0;
        io_if.confirm_key_raw  = 1'b0;
        io_if.continue_key_raw = 1'b0;
        io_if.output_data      = 32'h0;
        tick(3);
        check("reset_outputs", {io_if.confirmation, io_if.continue_button, io_if.waiting,
                                io_if.display_value}, 96'd0);
        reset = 1'b1;
        tick(4);

`ifdef IO_AUTOCONFIRM_EN
        io_if.output_data = 32'hA5A5_0006;
        io_if.is_output   = 1'b1;
        press(1'b0, 2'b00, 2, 32'hA5A5_0006);
        io_if.confirm_key_raw = 1'b0;
        exp_q[0].kind = 2'b10;
        tick(3);
        io_if.is_output = 1'b0;
        tick(6);
        check("auto_drained", 96'(exp_q.size()), 96'd0);
`else
        // 1: OUTPUT committed by one confirm press.
        io_if.output_data = 32'hCAFE_0001;
        io_if.is_output   = 1'b1;
        tick(3);
        check("t1_waiting", 96'(io_if.waiting), 96'd1);
        press(1'b0, 2'b10, 6, 32'hCAFE_0001);
        drain("t1_drained");
        check("t1_display", 96'(io_if.display_value), 96'h0000_0000_0000_0000_CAFE_0001);
        check("t1_not_waiting", 96'(io_if.waiting), 96'd0);

        // 2: PAUSE ignores confirm, commits on continue.
        io_if.output_data = 32'h5555_AAAA;
        io_if.is_input    = 1'b1;
        io_if.is_output   = 1'b1;
        tick(3);
        check("t2_waiting", 96'(io_if.waiting), 96'd1);
        io_if.confirm_key_raw = 1'b1;
        tick(10);
        io_if.confirm_key_raw = 1'b0;
        tick(8);
        press(1'b1, 2'b01, 6, 32'hCAFE_0001);
        drain("t2_drained");
        check("t2_display", 96'(io_if.display_value), 96'h0000_0000_0000_0000_CAFE_0001);

        // 3: bouncing confirm, one strobe 6 cycles after the last edge.
        io_if.output_data = 32'h1234_5678;
        io_if.is_output   = 1'b1;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            io_if.confirm_key_raw = 1'b1;
            tick(2);
            io_if.confirm_key_raw = 1'b0;
            tick(2);
        end
        press(1'b0, 2'b10, 6, 32'h1234_5678);
        drain("t3_drained");

        // 4: held key spans two INPUT requests, then release and re-press.
        io_if.output_data = 32'h0BAD_F00D;
        io_if.is_input    = 1'b1;
        tick(3);
        press(1'b0, 2'b10, 6, 32'h1234_5678);
        tick(10);
        io_if.is_input = 1'b0;
        tick(1);
        io_if.is_input = 1'b1;
        tick(15);
        check("t4_held_no_rearm", 96'(io_if.waiting), 96'd0);
        io_if.confirm_key_raw = 1'b0;
        tick(10);
        check("t4_rearmed", 96'(io_if.waiting), 96'd1);
        press(1'b0, 2'b10, 6, 32'h1234_5678);
        drain("t4_drained");
        check("t4_display", 96'(io_if.display_value), 96'h0000_0000_0000_0000_1234_5678);

        // 5: flush while armed, then asynchronous reset during a press.
        io_if.output_data = 32'hDEAD_BEEF;
        io_if.is_output   = 1'b1;
        tick(3);
        check("t5_armed", 96'(io_if.waiting), 96'd1);
        io_if.is_output = 1'b0;
        tick(2);
        check("t5_flushed", 96'(io_if.waiting), 96'd0);
        io_if.is_output = 1'b1;
        tick(3);
        io_if.confirm_key_raw = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        check("t5_async_reset", {io_if.confirmation, io_if.continue_button, io_if.waiting,
                                 io_if.display_value}, 96'd0);
        tick(2);
        reset = 1'b1;
        tick(15);
        check("t5_held_after_reset", 96'(io_if.waiting), 96'd0);
        io_if.confirm_key_raw = 1'b0;
        tick(10);
        check("t5_rearmed", 96'(io_if.waiting), 96'd1);
        press(1'b0, 2'b10, 6, 32'hDEAD_BEEF);
        drain("t5_drained");
`endif

        check("all_drained", 96'(exp_q.size()), 96'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
